// File: rtl/ev_drive_sequencer.sv
// EV drive speed sequencer: power-up precharge, PLC/HMI round-robin command grants,
// rate-limited speed ramp, brake override and latched e-stop fault.
module ev_drive_sequencer #(
    parameter int SPEED_W       = 8,
    parameter int RAMP_STEP     = 4,
    parameter int TICK_DIV      = 16,
    parameter int PRECHARGE_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               power_on,
    input  logic               estop,
    input  logic               fault_clr,
    input  logic               plc_req,
    input  logic [SPEED_W-1:0] plc_target,
    output logic               plc_gnt,
    input  logic               hmi_req,
    input  logic [SPEED_W-1:0] hmi_target,
    output logic               hmi_gnt,
    input  logic [3:0]         brake_in,
    output logic [SPEED_W-1:0] speed_out,
    output logic [2:0]         state_out,
    output logic               at_target,
    output logic               fault
);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam int PC_W = $clog2(PRECHARGE_CYC) + 1;
    localparam logic [TK_W-1:0]    TICK_LAST = TK_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0]    PC_LAST   = PC_W'(PRECHARGE_CYC - 1);
    localparam logic [SPEED_W-1:0] STEP_V    = SPEED_W'(RAMP_STEP);
    localparam logic [SPEED_W-1:0] ZERO_V    = '0;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_IDLE      = 3'd2,
        ST_RUN       = 3'd3,
        ST_BRAKE     = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t             state_r;
    logic [SPEED_W-1:0] speed_r;
    logic [SPEED_W-1:0] target_r;
    logic [TK_W-1:0]    tick_cnt_r;
    logic [PC_W-1:0]    pc_cnt_r;
    logic               last_hmi_r;
    logic               gnt_prev_r;
    logic               plc_gnt_r;
    logic               hmi_gnt_r;

    logic               tick_s;
    logic               brake_s;
    logic               grant_ok_s;
    logic               pick_plc_s;
    logic               pick_hmi_s;
    logic [SPEED_W-1:0] brake_val_s;
    logic [SPEED_W-1:0] ramp_speed_s;
    logic [SPEED_W-1:0] brake_speed_s;

    // Tick detect and round-robin grant selection; gnt_prev_r leaves a quiet cycle for req to drop
    always_comb begin
        tick_s     = (tick_cnt_r == TICK_LAST);
        brake_s    = (brake_in != 4'd0);
        grant_ok_s = ((state_r == ST_IDLE) || (state_r == ST_RUN)) && !estop && power_on
                     && !brake_s && !gnt_prev_r;
        pick_plc_s = grant_ok_s && plc_req && (!hmi_req || last_hmi_r);
        pick_hmi_s = grant_ok_s && hmi_req && (!plc_req || !last_hmi_r);
    end

    // Candidate speeds for a ramp tick in RUN and a decay tick in BRAKE, clamped so nothing overshoots
    always_comb begin
        ramp_speed_s  = speed_r;
        brake_speed_s = speed_r;
        brake_val_s   = SPEED_W'(brake_in);
        if (speed_r < target_r) begin
            if ((target_r - speed_r) > STEP_V) begin
                ramp_speed_s = speed_r + STEP_V;
            end else begin
                ramp_speed_s = target_r;
            end
        end else if (speed_r > target_r) begin
            if ((speed_r - target_r) > STEP_V) begin
                ramp_speed_s = speed_r - STEP_V;
            end else begin
                ramp_speed_s = target_r;
            end
        end else begin
            ramp_speed_s = speed_r;
        end
        if (brake_val_s > speed_r) begin
            brake_speed_s = ZERO_V;
        end else begin
            brake_speed_s = speed_r - brake_val_s;
        end
    end

    // Sequencer state, speed/target registers, tick and precharge counters, grant pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_OFF;
            speed_r    <= '0;
            target_r   <= '0;
            tick_cnt_r <= '0;
            pc_cnt_r   <= '0;
            last_hmi_r <= 1'b1;
            gnt_prev_r <= 1'b0;
            plc_gnt_r  <= 1'b0;
            hmi_gnt_r  <= 1'b0;
        end else if (!ena) begin
            plc_gnt_r <= 1'b0;
            hmi_gnt_r <= 1'b0;
        end else begin
            plc_gnt_r  <= pick_plc_s;
            hmi_gnt_r  <= pick_hmi_s;
            gnt_prev_r <= pick_plc_s | pick_hmi_s;
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TK_W'(1);
            if (pick_plc_s) begin
                target_r   <= plc_target;
                last_hmi_r <= 1'b0;
            end else if (pick_hmi_s) begin
                target_r   <= hmi_target;
                last_hmi_r <= 1'b1;
            end
            if (estop && (state_r != ST_FAULT)) begin
                state_r  <= ST_FAULT;
                speed_r  <= '0;
                target_r <= '0;
            end else if (!power_on && (state_r != ST_FAULT) && (state_r != ST_OFF)) begin
                state_r  <= ST_OFF;
                speed_r  <= '0;
                target_r <= '0;
            end else begin
                case (state_r)
                    ST_OFF: begin
                        speed_r  <= '0;
                        target_r <= '0;
                        if (power_on) begin
                            state_r  <= ST_PRECHARGE;
                            pc_cnt_r <= '0;
                        end
                    end
                    ST_PRECHARGE: begin
                        if (pc_cnt_r == PC_LAST) begin
                            state_r <= ST_IDLE;
                        end else begin
                            pc_cnt_r <= pc_cnt_r + PC_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (brake_s) begin
                            state_r <= ST_BRAKE;
                        end else if (gnt_prev_r && (target_r != ZERO_V)) begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tick_s) begin
                            speed_r <= ramp_speed_s;
                        end
                        if (brake_s) begin
                            state_r <= ST_BRAKE;
                        end else if ((speed_r == ZERO_V) && (target_r == ZERO_V)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_BRAKE: begin
                        if (tick_s) begin
                            speed_r <= brake_speed_s;
                        end
                        if (!brake_s) begin
                            state_r <= ((speed_r != ZERO_V) || (target_r != ZERO_V)) ? ST_RUN : ST_IDLE;
                        end
                    end
                    ST_FAULT: begin
                        speed_r  <= '0;
                        target_r <= '0;
                        if (fault_clr && !estop) begin
                            state_r <= ST_OFF;
                        end
                    end
                    default: begin
                        state_r  <= ST_FAULT;
                        speed_r  <= '0;
                        target_r <= '0;
                    end
                endcase
            end
        end
    end

    assign plc_gnt   = plc_gnt_r;
    assign hmi_gnt   = hmi_gnt_r;
    assign speed_out = speed_r;
    assign state_out = state_r;
    assign fault     = (state_r == ST_FAULT);
    assign at_target = (state_r == ST_RUN) && (speed_r == target_r);

endmodule

// File: tb/tb_ev_drive_sequencer.sv
// Self-checking bench for ev_drive_sequencer: vector table, directed corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_ev_drive_sequencer;
    localparam int TICK_DIV = 16;
    localparam int RAMP     = 4;
    localparam int PRE_CYC  = 8;

    logic       clk = 1'b0;
    logic       rst_n, ena, power_on, estop, fault_clr;
    logic       plc_req, hmi_req, plc_gnt, hmi_gnt, at_target, fault;
    logic [7:0] plc_target, hmi_target, speed_out;
    logic [3:0] brake_in;
    logic [2:0] state_out;

    int total = 0;
    int bad   = 0;

    ev_drive_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .power_on(power_on), .estop(estop),
        .fault_clr(fault_clr), .plc_req(plc_req), .plc_target(plc_target), .plc_gnt(plc_gnt),
        .hmi_req(hmi_req), .hmi_target(hmi_target), .hmi_gnt(hmi_gnt), .brake_in(brake_in),
        .speed_out(speed_out), .state_out(state_out), .at_target(at_target), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         pwr;
        bit         es;
        bit         fclr;
        logic [3:0] brk;
        int         cyc;
        int         st;
        int         spd;
        int         flt;
    } vec_t;
    vec_t tbl[$];

    // reference model state (post-edge view)
    int m_state, m_speed, m_target, m_en_cnt, m_pc_n;
    bit m_last_hmi, m_gprev, m_pg, m_hg;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_change(output int n);
        logic [7:0] prev;
        prev = speed_out;
        n = 0;
        while (n < 64 && speed_out == prev) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (speed_out == prev) begin
            bad++;
            $display("FAIL speed_change_timeout: speed stuck at %0d at %0t", prev, $time);
        end
    endtask

    task automatic wait_at_target();
        int n = 0;
        while (n < 400 && !at_target) begin
            @(negedge clk);
            n++;
        end
        chk("at_target_reached", int'(at_target), 1);
    endtask

    task automatic model_reset();
        m_state = 0; m_speed = 0; m_target = 0; m_en_cnt = 0; m_pc_n = 0;
        m_last_hmi = 1'b1; m_gprev = 1'b0; m_pg = 1'b0; m_hg = 1'b0;
    endtask

    // next state from the rules, using current inputs and the pre-edge model state
    task automatic model_step();
        int  ns, nspd, ntgt, d;
        bit  tick, ok, gp, gh, was_gnt;
        if (!ena) begin
            m_pg = 1'b0; m_hg = 1'b0;
            return;
        end
        ns = m_state; nspd = m_speed; ntgt = m_target;
        tick = (m_en_cnt % TICK_DIV) == TICK_DIV - 1;
        m_en_cnt++;
        ok = (m_state == 2 || m_state == 3) && !estop && power_on && brake_in == 0 && !m_gprev;
        gp = ok && plc_req && (!hmi_req || m_last_hmi);
        gh = ok && hmi_req && !gp;
        if (gp) begin ntgt = plc_target; m_last_hmi = 1'b0; end
        if (gh) begin ntgt = hmi_target; m_last_hmi = 1'b1; end
        was_gnt = m_gprev;
        m_gprev = gp | gh;
        if (estop && m_state != 5) begin
            ns = 5; nspd = 0; ntgt = 0;
        end else if (!power_on && m_state != 5 && m_state != 0) begin
            ns = 0; nspd = 0; ntgt = 0;
        end else if (m_state == 0) begin
            if (power_on) begin ns = 1; m_pc_n = 0; end
        end else if (m_state == 1) begin
            m_pc_n++;
            if (m_pc_n == PRE_CYC) ns = 2;
        end else if (m_state == 2) begin
            if (brake_in != 0) ns = 4;
            else if (was_gnt && m_target != 0) ns = 3;
        end else if (m_state == 3) begin
            if (tick) begin
                d = m_target - m_speed;
                if (d > RAMP) d = RAMP;
                if (d < -RAMP) d = -RAMP;
                nspd = m_speed + d;
            end
            if (brake_in != 0) ns = 4;
            else if (m_speed == 0 && m_target == 0) ns = 2;
        end else if (m_state == 4) begin
            if (tick) nspd = (m_speed > brake_in) ? m_speed - brake_in : 0;
            if (brake_in == 0) ns = (m_speed > 0 || m_target > 0) ? 3 : 2;
        end else if (m_state == 5) begin
            if (fault_clr && !estop) ns = 0;
        end
        m_state = ns; m_speed = nspd; m_target = ntgt; m_pg = gp; m_hg = gh;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_state"}, int'(state_out), 3'(0) | 0 + m_state);
        chk({tag, "_speed"}, int'(speed_out), m_speed);
        chk({tag, "_plc_gnt"}, int'(plc_gnt), int'(m_pg));
        chk({tag, "_hmi_gnt"}, int'(hmi_gnt), int'(m_hg));
        chk({tag, "_at_target"}, int'(at_target), int'(m_state == 3 && m_speed == m_target));
        chk({tag, "_fault"}, int'(fault), int'(m_state == 5));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1; power_on = 1'b0; estop = 1'b0; fault_clr = 1'b0;
        plc_req = 1'b0; hmi_req = 1'b0; plc_target = 8'd0; hmi_target = 8'd0; brake_in = 4'd0;
        #1;
        chk("rst_state", int'(state_out), 0);
        chk("rst_speed", int'(speed_out), 0);
        chk("rst_gnts", int'({plc_gnt, hmi_gnt}), 0);
        chk("rst_at_target_fault", int'({at_target, fault}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // en, pwr, estop, fclr, brake, cycles, state, speed, fault
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3, 0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8, 1, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1, 2, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 2, 4, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1, 2, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1, 5, 0, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 3, 5, 0, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2, 5, 0, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2, 0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8, 1, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1, 2, 0, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3, 0, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8, 1, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1, 2, 0, 0});
        foreach (tbl[i]) begin
            ena = tbl[i].en; power_on = tbl[i].pwr; estop = tbl[i].es;
            fault_clr = tbl[i].fclr; brake_in = tbl[i].brk;
            for (int k = 0; k < tbl[i].cyc; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_state", i), int'(state_out), tbl[i].st);
                chk($sformatf("vec%0d_speed", i), int'(speed_out), tbl[i].spd);
                chk($sformatf("vec%0d_fault", i), int'(fault), tbl[i].flt);
            end
        end

        // simultaneous requests from fresh pointer: PLC first, HMI two cycles later
        plc_req = 1'b1; plc_target = 8'd20; hmi_req = 1'b1; hmi_target = 8'd40;
        @(negedge clk);
        chk("arb1_plc_gnt", int'(plc_gnt), 1);
        chk("arb1_hmi_gnt", int'(hmi_gnt), 0);
        plc_req = 1'b0;
        @(negedge clk);
        chk("arb1_quiet", int'({plc_gnt, hmi_gnt}), 0);
        chk("arb1_run", int'(state_out), 3);
        @(negedge clk);
        chk("arb1_hmi_second", int'(hmi_gnt), 1);
        hmi_req = 1'b0;
        wait_at_target();
        chk("arb1_final_speed", int'(speed_out), 40);

        // brake from 40 by 3 per tick, release at 31, ramp back to 40
        brake_in = 4'd3;
        @(negedge clk);
        chk("brk_state", int'(state_out), 4);
        wait_change(n); chk("brk_37", int'(speed_out), 37);
        wait_change(n); chk("brk_34", int'(speed_out), 34); chk("brk_tick_gap", n, TICK_DIV);
        wait_change(n); chk("brk_31", int'(speed_out), 31);
        brake_in = 4'd0;
        @(negedge clk);
        chk("brk_release_run", int'(state_out), 3);
        wait_change(n); chk("rec_35", int'(speed_out), 35);
        wait_change(n); chk("rec_39", int'(speed_out), 39);
        wait_change(n); chk("rec_40", int'(speed_out), 40);
        chk("rec_at_target", int'(at_target), 1);

        // power cycle back to IDLE, then single PLC request for target 10
        power_on = 1'b0;
        @(negedge clk);
        chk("pwroff_state", int'(state_out), 0);
        chk("pwroff_speed", int'(speed_out), 0);
        power_on = 1'b1;
        repeat (PRE_CYC + 1) @(negedge clk);
        chk("repower_idle", int'(state_out), 2);
        plc_req = 1'b1; plc_target = 8'd10;
        @(negedge clk);
        chk("ramp_plc_gnt", int'(plc_gnt), 1);
        plc_req = 1'b0;
        @(negedge clk);
        chk("ramp_gnt_pulse", int'(plc_gnt), 0);
        chk("ramp_run", int'(state_out), 3);
        wait_change(n); chk("ramp_4", int'(speed_out), 4);
        wait_change(n); chk("ramp_8", int'(speed_out), 8); chk("ramp_gap1", n, TICK_DIV);
        wait_change(n); chk("ramp_10", int'(speed_out), 10); chk("ramp_gap2", n, TICK_DIV);
        chk("ramp_at_target", int'(at_target), 1);

        // second simultaneous pair after a PLC grant: HMI goes first
        plc_req = 1'b1; plc_target = 8'd50; hmi_req = 1'b1; hmi_target = 8'd30;
        @(negedge clk);
        chk("arb2_hmi_first", int'(hmi_gnt), 1);
        chk("arb2_plc_wait", int'(plc_gnt), 0);
        hmi_req = 1'b0;
        @(negedge clk);
        chk("arb2_quiet", int'({plc_gnt, hmi_gnt}), 0);
        @(negedge clk);
        chk("arb2_plc_second", int'(plc_gnt), 1);
        plc_req = 1'b0;
        wait_at_target();
        chk("arb2_final_speed", int'(speed_out), 50);

        // ena low mid-ramp freezes speed and tick phase
        plc_req = 1'b1; plc_target = 8'd90;
        @(negedge clk);
        chk("ena_plc_gnt", int'(plc_gnt), 1);
        plc_req = 1'b0;
        wait_change(n); chk("ena_54", int'(speed_out), 54);
        repeat (5) @(negedge clk);
        ena = 1'b0;
        repeat (50) @(negedge clk);
        chk("ena_hold_speed", int'(speed_out), 54);
        chk("ena_hold_state", int'(state_out), 3);
        chk("ena_gnts_low", int'({plc_gnt, hmi_gnt}), 0);
        ena = 1'b1;
        wait_change(n); chk("ena_resume_58", int'(speed_out), 58); chk("ena_tick_phase", n, TICK_DIV - 5);

        // e-stop mid-ramp, clear ignored while estop held
        estop = 1'b1;
        @(negedge clk);
        chk("es_state", int'(state_out), 5);
        chk("es_speed", int'(speed_out), 0);
        chk("es_fault", int'(fault), 1);
        fault_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("es_clr_ignored", int'(state_out), 5);
        estop = 1'b0;
        @(negedge clk);
        chk("es_cleared_off", int'(state_out), 0);
        chk("es_fault_low", int'(fault), 0);
        fault_clr = 1'b0;

        // async reset mid-RUN, checked between clock edges
        repeat (PRE_CYC + 1) @(negedge clk);
        plc_req = 1'b1; plc_target = 8'd100;
        @(negedge clk);
        plc_req = 1'b0;
        wait_change(n);
        chk("ar_pre_state", int'(state_out), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", int'(state_out), 0);
        chk("ar_speed", int'(speed_out), 0);
        chk("ar_outs", int'({plc_gnt, hmi_gnt, at_target, fault}), 0);

        // randomized traffic against the reference model
        @(negedge clk);
        power_on = 1'b1; estop = 1'b0; fault_clr = 1'b0; brake_in = 4'd0; ena = 1'b1;
        plc_req = 1'b0; hmi_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6000; c++) begin
            if (m_pg) plc_req = 1'b0;
            else if (!plc_req && $urandom_range(0, 15) == 0) begin
                plc_req = 1'b1;
                plc_target = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            end
            if (m_hg) hmi_req = 1'b0;
            else if (!hmi_req && $urandom_range(0, 15) == 0) begin
                hmi_req = 1'b1;
                hmi_target = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 499) == 0) power_on = ~power_on;
            if (estop) estop = ($urandom_range(0, 7) != 0);
            else estop = ($urandom_range(0, 699) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
            ena = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 79) == 0)
                brake_in = (brake_in != 4'd0) ? 4'd0 : 4'($urandom_range(1, 15));
            model_step();
            @(negedge clk);
            chk_outputs($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
